// File: rtl/lab3_cache_write_buffer_pkg.sv
// Memory request/response message formats shared by the cache write buffer and its neighbours.
package lab3_cache_write_buffer_pkg;

  localparam logic [2:0] MEM_RD   = 3'd0;
  localparam logic [2:0] MEM_WR   = 3'd1;
  localparam logic [2:0] MEM_INIT = 3'd2;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage

// File: rtl/lab3_cache_write_buffer.sv
// Write buffer between cache and memory: writes are acked immediately and drained in order; reads
// wait for the buffer to drain. Define LAB3_CACHE_WRITE_BUFFER_FWD_EN to serve reads from buffered writes.
module lab3_cache_write_buffer
  import lab3_cache_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         creq_val,
  output logic         creq_rdy,
  input  mem_req_4B_t  creq_msg,
  output logic         cresp_val,
  input  logic         cresp_rdy,
  output mem_resp_4B_t cresp_msg,
  output logic         mreq_val,
  input  logic         mreq_rdy,
  output mem_req_4B_t  mreq_msg,
  input  logic         mresp_val,
  output logic         mresp_rdy,
  input  mem_resp_4B_t mresp_msg,
  output logic         wb_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {IDLE, DRAIN, RD_REQ, RD_WAIT, RD_RESP} state_t;

  state_t       state, state_n;
  mem_req_4B_t  fifo [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, outst;
  logic         resp_val;
  mem_resp_4B_t resp_msg, resp_next;
  mem_req_4B_t  rd_req;

  logic creq_is_wr, creq_is_rd, fifo_full, fifo_empty;
  logic enq, rd_acc, drain_val, pop, wr_resp, rd_resp, resp_load, fwd_hit;
  logic unused_mresp;

  assign creq_is_wr = (creq_msg.type_ == MEM_WR) || (creq_msg.type_ == MEM_INIT);
  assign creq_is_rd = (creq_msg.type_ == MEM_RD);
  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);

  // Full is judged on the count at cycle start, so a same-cycle pop never frees a slot early.
  assign creq_rdy  = (state == IDLE) && !resp_val && (creq_is_rd || (creq_is_wr && !fifo_full));
  assign enq       = creq_val && creq_rdy && creq_is_wr;
  assign rd_acc    = creq_val && creq_rdy && creq_is_rd;

  // Writes drain whenever the read FSM is not using the memory port; outstanding caps at DEPTH.
  assign drain_val = !fifo_empty && (state != RD_REQ) && (outst < CW'(DEPTH));
  assign mreq_val  = (state == RD_REQ) || drain_val;
  assign mreq_msg  = (state == RD_REQ) ? rd_req : fifo[head];
  assign pop       = drain_val && mreq_rdy;

  assign mresp_rdy = 1'b1;
  assign wr_resp   = mresp_val && ((mresp_msg.type_ == MEM_WR) || (mresp_msg.type_ == MEM_INIT))
                     && (outst != '0);
  assign rd_resp   = mresp_val && (mresp_msg.type_ == MEM_RD) && (state == RD_WAIT);
  assign unused_mresp = ^{mresp_msg.opaque, mresp_msg.test};

  assign cresp_val = resp_val;
  assign cresp_msg = resp_msg;
  assign wb_empty  = fifo_empty && (outst == '0);

`ifdef LAB3_CACHE_WRITE_BUFFER_FWD_EN
  logic [31:0] fwd_data;

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (fifo[head + PW'(i)].addr[31:2] == creq_msg.addr[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo[head + PW'(i)].data;
      end
    end
  end
`else
  assign fwd_hit = 1'b0;
`endif

  // Response register load source: write ack, memory read data or forwarded data.
  always_comb begin
    resp_load = 1'b0;
    resp_next = '0;
    if (enq) begin
      resp_load        = 1'b1;
      resp_next.type_  = creq_msg.type_;
      resp_next.opaque = creq_msg.opaque;
    end else if (rd_resp) begin
      resp_load        = 1'b1;
      resp_next.type_  = MEM_RD;
      resp_next.opaque = rd_req.opaque;
      resp_next.len    = mresp_msg.len;
      resp_next.data   = mresp_msg.data;
`ifdef LAB3_CACHE_WRITE_BUFFER_FWD_EN
    end else if (rd_acc && fwd_hit) begin
      resp_load        = 1'b1;
      resp_next.type_  = MEM_RD;
      resp_next.opaque = creq_msg.opaque;
      resp_next.len    = creq_msg.len;
      resp_next.data   = fwd_data;
`endif
    end
  end

  // Read FSM next state.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (rd_acc) state_n = fwd_hit ? RD_RESP : (wb_empty ? RD_REQ : DRAIN);
      DRAIN:   if (wb_empty) state_n = RD_REQ;
      RD_REQ:  if (mreq_rdy) state_n = RD_WAIT;
      RD_WAIT: if (rd_resp) state_n = RD_RESP;
      RD_RESP: if (cresp_rdy) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      outst    <= '0;
      resp_val <= 1'b0;
    end else begin
      state <= state_n;
      if (enq) tail <= (tail == PW'(DEPTH - 1)) ? '0 : tail + PW'(1);
      if (pop) head <= (head == PW'(DEPTH - 1)) ? '0 : head + PW'(1);
      case ({enq, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      case ({pop, wr_resp})
        2'b10:   outst <= outst + CW'(1);
        2'b01:   outst <= outst - CW'(1);
        default: outst <= outst;
      endcase
      if (resp_val && cresp_rdy) resp_val <= 1'b0;
      if (resp_load) resp_val <= 1'b1;
    end
  end

  // Payload storage; not reset.
  always_ff @(posedge clk) begin
    if (enq) fifo[tail] <= creq_msg;
    if (rd_acc) rd_req <= creq_msg;
    if (resp_load) resp_msg <= resp_next;
  end

endmodule

// File: tb/tb_lab3_cache_write_buffer.sv
// Scoreboard bench for lab3_cache_write_buffer: directed writes/reads, a simple memory model,
// and monitors comparing every cresp/mreq handshake against queued expectations.
module tb_lab3_cache_write_buffer;
  import lab3_cache_write_buffer_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         creq_val, creq_rdy;
  mem_req_4B_t  creq_msg;
  logic         cresp_val, cresp_rdy;
  mem_resp_4B_t cresp_msg;
  logic         mreq_val, mreq_rdy;
  mem_req_4B_t  mreq_msg;
  logic         mresp_val, mresp_rdy;
  mem_resp_4B_t mresp_msg;
  logic         wb_empty;

  always #5 clk = ~clk;

  lab3_cache_write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .creq_val(creq_val), .creq_rdy(creq_rdy), .creq_msg(creq_msg),
    .cresp_val(cresp_val), .cresp_rdy(cresp_rdy), .cresp_msg(cresp_msg),
    .mreq_val(mreq_val), .mreq_rdy(mreq_rdy), .mreq_msg(mreq_msg),
    .mresp_val(mresp_val), .mresp_rdy(mresp_rdy), .mresp_msg(mresp_msg),
    .wb_empty(wb_empty)
  );

  typedef struct {
    logic [2:0]  t;
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_cresp[$];
  exp_t exp_mreq[$];
  logic [7:0] opc = 8'd0;
  bit fwd_en;

  logic mem_hold;
  logic [31:0] mem [logic [31:0]];
  mem_resp_4B_t pend[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // cresp monitor
  exp_t ce;
  always @(negedge clk) begin
    if (!reset && cresp_val && cresp_rdy) begin
      if (exp_cresp.size() == 0) fail_now("cresp_unexpected");
      else begin
        ce = exp_cresp.pop_front();
        check("cresp_type", 32'(cresp_msg.type_), 32'(ce.t));
        check("cresp_opaque", 32'(cresp_msg.opaque), 32'(ce.op));
        check("cresp_test_len", 32'({cresp_msg.test, cresp_msg.len}), 32'd0);
        check("cresp_data", cresp_msg.data, ce.data);
      end
    end
  end

  // mreq monitor
  exp_t me;
  always @(negedge clk) begin
    if (!reset && mreq_val && mreq_rdy) begin
      if (exp_mreq.size() == 0) fail_now("mreq_unexpected");
      else begin
        me = exp_mreq.pop_front();
        check("mreq_type", 32'(mreq_msg.type_), 32'(me.t));
        check("mreq_opaque", 32'(mreq_msg.opaque), 32'(me.op));
        check("mreq_addr", mreq_msg.addr, me.addr);
        if (me.t != MEM_RD) check("mreq_data", mreq_msg.data, me.data);
      end
    end
  end

  // Memory model: responds the cycle after a request; mem_hold stalls responses.
  bit          m_freq, m_fresp;
  mem_req_4B_t m_rq;
  mem_resp_4B_t m_r;
  initial begin
    mresp_val = 1'b0;
    mresp_msg = '0;
    forever begin
      @(negedge clk);
      m_freq  = !reset && mreq_val && mreq_rdy;
      m_rq    = mreq_msg;
      m_fresp = mresp_val && mresp_rdy;
      @(posedge clk);
      #1;
      if (m_fresp) void'(pend.pop_front());
      if (m_freq) begin
        m_r = '0;
        m_r.type_  = m_rq.type_;
        m_r.opaque = m_rq.opaque;
        if (m_rq.type_ == MEM_RD) m_r.data = mem.exists(m_rq.addr) ? mem[m_rq.addr] : 32'd0;
        else mem[m_rq.addr] = m_rq.data;
        pend.push_back(m_r);
      end
      mresp_val = !mem_hold && (pend.size() > 0);
      if (pend.size() > 0) mresp_msg = pend[0];
    end
  end

  task automatic drive(input logic [2:0] t, input logic [7:0] op, input logic [31:0] addr,
                       input logic [31:0] data);
    @(posedge clk);
    #1;
    creq_val        = 1'b1;
    creq_msg        = '0;
    creq_msg.type_  = t;
    creq_msg.opaque = op;
    creq_msg.addr   = addr;
    creq_msg.data   = data;
  endtask

  task automatic wait_accept(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (creq_rdy) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now({name, "_accept_timeout"});
    @(posedge clk);
    #1;
    creq_val = 1'b0;
  endtask

  task automatic prep_wr(input logic [31:0] addr, input logic [31:0] data);
    exp_cresp.push_back('{t: MEM_WR, op: opc, addr: 32'd0, data: 32'd0});
    exp_mreq.push_back('{t: MEM_WR, op: opc, addr: addr, data: data});
    drive(MEM_WR, opc, addr, data);
    opc++;
  endtask

  task automatic send_wr(input logic [31:0] addr, input logic [31:0] data);
    prep_wr(addr, data);
    wait_accept("wr");
  endtask

  task automatic send_rd(input logic [31:0] addr, input logic [31:0] exp_data, input bit to_mem);
    exp_cresp.push_back('{t: MEM_RD, op: opc, addr: 32'd0, data: exp_data});
    if (to_mem) exp_mreq.push_back('{t: MEM_RD, op: opc, addr: addr, data: 32'd0});
    drive(MEM_RD, opc, addr, 32'd0);
    opc++;
    wait_accept("rd");
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (exp_cresp.size() == 0 && exp_mreq.size() == 0 && pend.size() == 0 && wb_empty
          && !cresp_val) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now({name, "_idle_timeout"});
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clk);
    check({name, "_cresp_val"}, 32'(cresp_val), 32'd0);
    check({name, "_mreq_val"}, 32'(mreq_val), 32'd0);
    check({name, "_mresp_rdy"}, 32'(mresp_rdy), 32'd1);
    check({name, "_creq_rdy"}, 32'(creq_rdy), 32'd1);
    check({name, "_wb_empty"}, 32'(wb_empty), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef LAB3_CACHE_WRITE_BUFFER_FWD_EN
    fwd_en = 1'b1;
`else
    fwd_en = 1'b0;
`endif
    reset     = 1'b1;
    creq_val  = 1'b0;
    creq_msg  = '0;
    creq_msg.type_ = MEM_WR;
    cresp_rdy = 1'b1;
    mreq_rdy  = 1'b1;
    mem_hold  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_outputs("reset");

    // Three writes held at the memory port, then drained in order.
    mreq_rdy = 1'b0;
    send_wr(32'h1000, 32'hA1);
    send_wr(32'h1004, 32'hA2);
    send_wr(32'h1008, 32'hA3);
    repeat (2) @(negedge clk);
    check("t1_acks_left", 32'(exp_cresp.size()), 32'd0);
    check("t1_mreq_val", 32'(mreq_val), 32'd1);
    check("t1_head_addr", mreq_msg.addr, 32'h1000);
    check("t1_wb_empty", 32'(wb_empty), 32'd0);
    @(posedge clk);
    #1;
    mreq_rdy = 1'b1;
    wait_idle("t1");

    // Fifth write stalls on a full FIFO until one pop.
    mreq_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_wr(32'h6000 + 32'(4 * i), 32'h600 + 32'(i));
    prep_wr(32'h6010, 32'h604);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_full_creq_rdy", 32'(creq_rdy), 32'd0);
    end
    @(posedge clk);
    #1;
    mreq_rdy = 1'b1;
    wait_accept("t2_fifth");
    wait_idle("t2");

    // Read-after-write to 0x2000.
    mreq_rdy = 1'b0;
    send_wr(32'h2000, 32'hCAFE);
    send_rd(32'h2000, 32'hCAFE, !fwd_en);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    mreq_rdy = 1'b1;
    wait_idle("t3");

    // Read into an empty buffer: mreq next cycle, cresp one cycle after the mresp.
    send_rd(32'h1004, 32'hA2, 1'b1);
    @(negedge clk);
    check("lat_mreq_val", 32'(mreq_val), 32'd1);
    check("lat_mreq_addr", mreq_msg.addr, 32'h1004);
    @(negedge clk);
    check("lat_mresp_val", 32'(mresp_val), 32'd1);
    check("lat_cresp_early", 32'(cresp_val), 32'd0);
    @(negedge clk);
    check("lat_cresp_val", 32'(cresp_val), 32'd1);
    wait_idle("lat");

    // Two writes to 0x3000 then a read: youngest data returned.
    mreq_rdy = 1'b0;
    send_wr(32'h3000, 32'h11);
    send_wr(32'h3000, 32'h22);
    send_rd(32'h3000, 32'h22, !fwd_en);
    @(negedge clk);
    if (fwd_en) check("t4_fwd_cresp_val", 32'(cresp_val), 32'd1);
    else        check("t4_drain_cresp_val", 32'(cresp_val), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    mreq_rdy = 1'b1;
    wait_idle("t4");

    // Reset while the read waits for memory; the late mresp must be absorbed silently.
    mem_hold = 1'b1;
    exp_mreq.push_back('{t: MEM_RD, op: opc, addr: 32'h1008, data: 32'd0});
    drive(MEM_RD, opc, 32'h1008, 32'd0);
    opc++;
    wait_accept("t5_rd");
    begin
      bit ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (pend.size() > 0) begin ok = 1'b1; break; end
      end
      if (!ok) fail_now("t5_mreq_timeout");
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_outputs("t5_after_reset");
    @(posedge clk);
    #1;
    mem_hold = 1'b0;
    @(negedge clk);
    check("t5_late_mresp_val", 32'(mresp_val & mresp_rdy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_cresp", 32'(cresp_val), 32'd0);
    end
    wait_idle("t5");

    // Pointer wrap over 2*DEPTH writes.
    for (int i = 0; i < 8; i++) send_wr(32'h5000 + 32'(4 * i), 32'(i * 32'h101));
    wait_idle("t6_wrap");

    // Enqueue and pop together at count 2: exactly two more slots remain afterwards.
    mreq_rdy = 1'b0;
    send_wr(32'h7000, 32'h70);
    send_wr(32'h7004, 32'h71);
    prep_wr(32'h7008, 32'h72);
    mreq_rdy = 1'b1;
    wait_accept("t6_simul");
    mreq_rdy = 1'b0;
    send_wr(32'h700C, 32'h73);
    send_wr(32'h7010, 32'h74);
    prep_wr(32'h7014, 32'h75);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t6_count2_full", 32'(creq_rdy), 32'd0);
    end
    @(posedge clk);
    #1;
    mreq_rdy = 1'b1;
    wait_accept("t6_last");
    wait_idle("t6");

    check("end_cresp_left", 32'(exp_cresp.size()), 32'd0);
    check("end_mreq_left", 32'(exp_mreq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
